// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: default widths, architectural register
// indices and common typedefs used by decode, regfile and syscall blocks.
package mips_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 2 ** DEF_ADDR_W;

  localparam int unsigned REG_ZERO = 0;
  localparam int unsigned REG_V0   = 2;
  localparam int unsigned REG_A0   = 4;

  typedef logic [DEF_ADDR_W-1:0] reg_idx_t;
  typedef logic [DEF_DATA_W-1:0] word_t;

  // True when the index names the hardwired-zero register.
  function automatic logic is_reg_zero(input reg_idx_t idx);
    return idx == reg_idx_t'(REG_ZERO);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard. A reservation marks a register as awaiting
// writeback; a write clears it. Reservation wins on a same-edge collision
// because it stands for a younger producer. Register 0 is never busy.
module regfile_scoreboard
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic                 rsv_en,
  input  logic [ADDR_W-1:0]    rsv_addr,
  output logic [2**ADDR_W-1:0] busy_vec
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] w_busy_nxt;

  // Next busy state: clear on write, then set on reserve so reserve has priority.
  always_comb begin
    w_busy_nxt = r_busy;
    if (wr_en && (wr_addr != '0)) begin
      w_busy_nxt[wr_addr] = 1'b0;
    end
    if (rsv_en && (rsv_addr != '0)) begin
      w_busy_nxt[rsv_addr] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  // Busy bit register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  assign busy_vec = r_busy;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port general-purpose register file: NUM_READ registered read ports
// with write-first bypass, one write port, hardwired-zero register 0, a busy
// scoreboard for pending writebacks and two architectural taps.
module regfile_mp
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned NUM_READ = 2,
  parameter int unsigned TAP0_IDX = REG_V0,
  parameter int unsigned TAP1_IDX = REG_A0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_READ-1:0]          rd_en,
  input  logic [NUM_READ*ADDR_W-1:0]   rd_addr,
  output logic [NUM_READ*DATA_W-1:0]   rd_data,
  output logic [NUM_READ-1:0]          rd_busy,
  input  logic                         wr_en,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic [DATA_W-1:0]            wr_data,
  input  logic                         rsv_en,
  input  logic [ADDR_W-1:0]            rsv_addr,
  output logic [2**ADDR_W-1:0]         busy_vec,
  output logic [DATA_W-1:0]            tap0,
  output logic [DATA_W-1:0]            tap1
);

  localparam int unsigned        DEPTH  = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0]  TAP0_A = ADDR_W'(TAP0_IDX);
  localparam logic [ADDR_W-1:0]  TAP1_A = ADDR_W'(TAP1_IDX);

  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [DEPTH-1:0]    w_busy_vec;
  logic                w_wr_ok;

  assign w_wr_ok = wr_en && (wr_addr != '0);

  // Storage array; entry 0 is never written so it stays zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem <= '{default: '0};
    end else if (w_wr_ok) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  regfile_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .busy_vec (w_busy_vec)
  );

  assign busy_vec = w_busy_vec;

  // Taps show committed storage only; no bypass from the write port.
  assign tap0 = r_mem[TAP0_A];
  assign tap1 = r_mem[TAP1_A];

  for (genvar p = 0; p < NUM_READ; p++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_val;
    logic              w_busy;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_busy;

    assign w_addr = rd_addr[p*ADDR_W +: ADDR_W];

    // Select read value: zero register, same-edge write bypass, else storage.
    // On bypass the busy flag is the post-write state, i.e. set only when the
    // same edge also reserves this register.
    always_comb begin
      w_val  = r_mem[w_addr];
      w_busy = w_busy_vec[w_addr];
      if (w_addr == '0) begin
        w_val  = '0;
        w_busy = 1'b0;
      end else if (wr_en && (wr_addr == w_addr)) begin
        w_val  = wr_data;
        w_busy = rsv_en && (rsv_addr == w_addr);
      end
    end

    // Read port output register; holds its value while the strobe is low.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_rd_data <= '0;
        r_rd_busy <= 1'b0;
      end else if (rd_en[p]) begin
        r_rd_data <= w_val;
        r_rd_busy <= w_busy;
      end
    end

    assign rd_data[p*DATA_W +: DATA_W] = r_rd_data;
    assign rd_busy[p]                  = r_rd_busy;
  end

endmodule
